// File: rtl/milk_mover_pkg.sv
// Shared OLED screen geometry, sprite sizes and mover state encoding.
// Imported by the milk-carton mover and its bus interface.
package oled_pkg;

  localparam int SCREEN_W  = 96;
  localparam int SCREEN_H  = 64;
  localparam int PIX_IDX_W = 13;
  localparam int COORD_W   = 7;
  localparam int RGB565_W  = 16;

  localparam int MILK_W = 9;
  localparam int MILK_H = 17;

  localparam int X_MAX_DEF = SCREEN_W - MILK_W;
  localparam int Y_MAX_DEF = SCREEN_H - MILK_H;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    FALL   = 2'd1,
    LANDED = 2'd2
  } mover_state_t;

  // Signed 8-bit input so an underflow (0-1) clamps to 0 instead of 127.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic signed [7:0] v,
                                                      input logic signed [7:0] hi);
    if (v < 8'sd0) begin
      return '0;
    end else if (v > hi) begin
      return hi[COORD_W-1:0];
    end else begin
      return v[COORD_W-1:0];
    end
  endfunction

endpackage

// File: rtl/milk_mover_if.sv
// Pushbutton inputs and sprite position outputs of the milk-carton mover.
// master = button source / position consumer, slave = the mover itself.
interface milk_mover_if;
  import oled_pkg::*;

  logic               btn_l;
  logic               btn_r;
  logic               btn_u;
  logic               btn_d;
  logic               btn_c;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               falling;
  logic               landed;

  modport master (
    output btn_l, btn_r, btn_u, btn_d, btn_c,
    input  x, y, falling, landed
  );

  modport slave (
    input  btn_l, btn_r, btn_u, btn_d, btn_c,
    output x, y, falling, landed
  );

endinterface

// File: rtl/milk_mover_btn_sync.sv
// Two-flop synchroniser for a raw asynchronous button, plus a one-cycle
// rising-edge pulse taken on the synchronised level.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o  = sync_q;
  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/milk_mover.sv
// Milk-carton sprite position stage: manual nudging plus a gravity drop.
// Define MILK_MOVER_WRAP_EN to make horizontal motion wrap instead of clamp.
module milk_mover
  import oled_pkg::*;
#(
  parameter int STEP_DIV   = 1_000_000,
  parameter int GRAV_DIV   = 4,
  parameter int VMAX       = 4,
  parameter int LAND_STEPS = 50,
  parameter int X_MAX      = X_MAX_DEF,
  parameter int Y_MAX      = Y_MAX_DEF,
  parameter int X_INIT     = 43,
  parameter int Y_INIT     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  milk_mover_if.slave  mv
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int GRAV_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam int LAND_W = (LAND_STEPS > 1) ? $clog2(LAND_STEPS) : 1;
  localparam int VEL_W  = $clog2(VMAX + 1);

  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [GRAV_W-1:0]  GRAV_LAST = GRAV_W'(GRAV_DIV - 1);
  localparam logic [LAND_W-1:0]  LAND_LAST = LAND_W'(LAND_STEPS - 1);
  localparam logic [VEL_W-1:0]   VMAX_C    = VEL_W'(VMAX);
  localparam logic [COORD_W-1:0] X_INIT_C  = COORD_W'(X_INIT);
  localparam logic [COORD_W-1:0] Y_INIT_C  = COORD_W'(Y_INIT);
  localparam logic [COORD_W-1:0] Y_MAX_C   = COORD_W'(Y_MAX);
  localparam logic signed [7:0]  X_MAX_S   = 8'(X_MAX);
  localparam logic signed [7:0]  Y_MAX_S   = 8'(Y_MAX);

  // ---------------- button conditioning ----------------
  logic [3:0] dir_raw;
  logic [3:0] dir_sync;
  logic [3:0] dir_pulse_unused;
  logic       c_sync_unused;
  logic       c_pulse;

  assign dir_raw = {mv.btn_d, mv.btn_u, mv.btn_r, mv.btn_l};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dir_sync
      btn_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (dir_raw[gi]),
        .sync_o  (dir_sync[gi]),
        .pulse_o (dir_pulse_unused[gi])
      );
    end
  endgenerate

  btn_sync u_c_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (mv.btn_c),
    .sync_o  (c_sync_unused),
    .pulse_o (c_pulse)
  );

  logic l_s, r_s, u_s, d_s;
  assign l_s = dir_sync[0];
  assign r_s = dir_sync[1];
  assign u_s = dir_sync[2];
  assign d_s = dir_sync[3];

  // ---------------- state and datapath registers ----------------
  mover_state_t        state_q, state_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [GRAV_W-1:0]   grav_cnt_q, grav_cnt_d;
  logic [LAND_W-1:0]   land_cnt_q, land_cnt_d;
  logic [VEL_W-1:0]    vel_q, vel_d;
  logic [COORD_W-1:0]  x_q, x_d;
  logic [COORD_W-1:0]  y_q, y_d;

  logic step_tick;
  assign step_tick  = (step_cnt_q == STEP_LAST);
  assign step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;

  // ---------------- motion arithmetic ----------------
  logic signed [7:0]  dx, dy;
  logic signed [7:0]  x_sum, y_msum, y_fsum;
  logic [COORD_W-1:0] x_step, y_manual, y_fall;
  logic               land_now, land_done;

  always_comb begin
    dx = 8'sd0;
    if (r_s && !l_s) begin
      dx = 8'sd1;
    end else if (l_s && !r_s) begin
      dx = -8'sd1;
    end
    dy = 8'sd0;
    if (d_s && !u_s) begin
      dy = 8'sd1;
    end else if (u_s && !d_s) begin
      dy = -8'sd1;
    end
  end

  assign x_sum  = $signed({1'b0, x_q}) + dx;
  assign y_msum = $signed({1'b0, y_q}) + dy;
  assign y_fsum = $signed({1'b0, y_q}) + $signed({{(8-VEL_W){1'b0}}, vel_q});

  always_comb begin
`ifdef MILK_MOVER_WRAP_EN
    if (x_sum < 8'sd0) begin
      x_step = X_MAX_S[COORD_W-1:0];
    end else if (x_sum > X_MAX_S) begin
      x_step = '0;
    end else begin
      x_step = x_sum[COORD_W-1:0];
    end
`else
    x_step = clamp_coord(x_sum, X_MAX_S);
`endif
  end

  assign y_manual  = clamp_coord(y_msum, Y_MAX_S);
  assign y_fall    = clamp_coord(y_fsum, Y_MAX_S);
  assign land_now  = step_tick && (y_fall == Y_MAX_C);
  assign land_done = step_tick && (land_cnt_q == LAND_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      MANUAL:  if (c_pulse) state_d = FALL;
      FALL:    if (land_now) state_d = LANDED;
      LANDED:  if (c_pulse || land_done) state_d = MANUAL;
      default: state_d = MANUAL;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    mv.falling = (state_q == FALL);
    mv.landed  = (state_q == LANDED);
  end

  assign mv.x = x_q;
  assign mv.y = y_q;

  // ---------------- datapath next values ----------------
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    vel_d      = vel_q;
    grav_cnt_d = grav_cnt_q;
    land_cnt_d = land_cnt_q;
    case (state_q)
      MANUAL: begin
        // A same-cycle press still takes this step's move before dropping.
        if (step_tick) begin
          x_d = x_step;
          y_d = y_manual;
        end
        if (c_pulse) begin
          vel_d      = VEL_W'(1);
          grav_cnt_d = '0;
        end
      end
      FALL: begin
        if (step_tick) begin
          x_d = x_step;
          y_d = y_fall;
          if (grav_cnt_q == GRAV_LAST) begin
            grav_cnt_d = '0;
            if (vel_q != VMAX_C) vel_d = vel_q + 1'b1;
          end else begin
            grav_cnt_d = grav_cnt_q + 1'b1;
          end
          if (land_now) begin
            vel_d      = '0;
            land_cnt_d = '0;
          end
        end
      end
      LANDED: begin
        if (c_pulse) begin
          x_d        = X_INIT_C;
          y_d        = Y_INIT_C;
          land_cnt_d = '0;
        end else if (land_done) begin
          land_cnt_d = '0;
        end else if (step_tick) begin
          land_cnt_d = land_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      grav_cnt_q <= '0;
      land_cnt_q <= '0;
      vel_q      <= '0;
      x_q        <= X_INIT_C;
      y_q        <= Y_INIT_C;
    end else begin
      step_cnt_q <= step_cnt_d;
      grav_cnt_q <= grav_cnt_d;
      land_cnt_q <= land_cnt_d;
      vel_q      <= vel_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

endmodule

// File: tb/tb_milk_mover.sv
// Directed bench for milk_mover with a 4-cycle step period; every position
// sample is taken 1ns after the clock edge that carries a step update.
module tb_milk_mover;
  import oled_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  milk_mover_if bus ();

  milk_mover #(
    .STEP_DIV   (4),
    .GRAV_DIV   (2),
    .VMAX       (3),
    .LAND_STEPS (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mv    (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int step_no     = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one motion step and report the position.
  task automatic tick();
    repeat (4) @(posedge clk);
    #1;
    step_no++;
    $display("step %0d: x=%0d y=%0d falling=%0b landed=%0b",
             step_no, bus.x, bus.y, bus.falling, bus.landed);
  endtask

  initial begin
    logic [7:0] exp_x;
    logic [7:0] left_x [3];
    logic [7:0] steer_x [2];
    logic [7:0] fall_y [18];
    logic [7:0] fall2_y [8];

`ifdef MILK_MOVER_WRAP_EN
    left_x  = '{8'd0, 8'd87, 8'd86};
    steer_x = '{8'd87, 8'd0};
`else
    left_x  = '{8'd0, 8'd0, 8'd0};
    steer_x = '{8'd1, 8'd2};
`endif
    fall_y  = '{8'd1, 8'd2, 8'd4, 8'd6, 8'd9, 8'd12, 8'd15, 8'd18, 8'd21,
                8'd24, 8'd27, 8'd30, 8'd33, 8'd36, 8'd39, 8'd42, 8'd45, 8'd47};
    fall2_y = '{8'd3, 8'd4, 8'd6, 8'd8, 8'd11, 8'd14, 8'd17, 8'd20};

    bus.btn_l = 1'b0;
    bus.btn_r = 1'b0;
    bus.btn_u = 1'b0;
    bus.btn_d = 1'b0;
    bus.btn_c = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #10;
    check("rst_x", 8'(bus.x), 8'd43);
    check("rst_y", 8'(bus.y), 8'd0);
    check("rst_falling", 8'(bus.falling), 8'd0);
    check("rst_landed", 8'(bus.landed), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hold right for 10 steps
    bus.btn_r = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("right_x", 8'(bus.x), 8'(43 + i));
      check("right_y", 8'(bus.y), 8'd0);
      check("right_falling", 8'(bus.falling), 8'd0);
    end

    // Walk left down to x=1, then past the left edge
    bus.btn_r = 1'b0;
    bus.btn_l = 1'b1;
    for (int i = 1; i <= 52; i++) begin
      tick();
      check("left_walk_x", 8'(bus.x), 8'(53 - i));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("left_edge_x", 8'(bus.x), left_x[i]);
    end
    exp_x = left_x[2];

    // Left and right together cancel
    bus.btn_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lr_cancel_x", 8'(bus.x), exp_x);
    end

    // Drop from y=0 while steering right for the first two steps
    bus.btn_l = 1'b0;
    bus.btn_c = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i == 0) bus.btn_c = 1'b0;
      if (i == 1) bus.btn_r = 1'b0;
      if (i < 2) exp_x = steer_x[i];
      check("fall_y", 8'(bus.y), fall_y[i]);
      check("fall_x", 8'(bus.x), exp_x);
      check("fall_falling", 8'(bus.falling), (i < 17) ? 8'd1 : 8'd0);
      check("fall_landed", 8'(bus.landed), (i == 17) ? 8'd1 : 8'd0);
    end

    // LANDED times out after 3 steps with position frozen
    for (int i = 0; i < 3; i++) begin
      tick();
      check("land_landed", 8'(bus.landed), (i < 2) ? 8'd1 : 8'd0);
      check("land_y", 8'(bus.y), 8'd47);
      check("land_x", 8'(bus.x), exp_x);
    end
    check("land_falling", 8'(bus.falling), 8'd0);

    // Drop from the floor lands on the first step
    bus.btn_c = 1'b1;
    tick();
    bus.btn_c = 1'b0;
    check("floor_drop_landed", 8'(bus.landed), 8'd1);
    check("floor_drop_falling", 8'(bus.falling), 8'd0);
    check("floor_drop_y", 8'(bus.y), 8'd47);

    // Respawn from LANDED at step 1, right after the pulse registers
    tick();
    check("respawn_pre_landed", 8'(bus.landed), 8'd1);
    bus.btn_c = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("respawn: x=%0d y=%0d landed=%0b", bus.x, bus.y, bus.landed);
    check("respawn_x", 8'(bus.x), 8'd43);
    check("respawn_y", 8'(bus.y), 8'd0);
    check("respawn_landed", 8'(bus.landed), 8'd0);
    check("respawn_falling", 8'(bus.falling), 8'd0);
    @(posedge clk);
    #1;
    bus.btn_c = 1'b0;

    // Move down to y=2, then drop and interrupt with reset at y=20
    bus.btn_d = 1'b1;
    tick();
    check("down_y1", 8'(bus.y), 8'd1);
    tick();
    check("down_y2", 8'(bus.y), 8'd2);
    bus.btn_d = 1'b0;
    bus.btn_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) bus.btn_c = 1'b0;
      check("fall2_y", 8'(bus.y), fall2_y[i]);
      check("fall2_falling", 8'(bus.falling), 8'd1);
    end
    #5 rst_n = 1'b0;
    #1;
    $display("async reset: x=%0d y=%0d falling=%0b", bus.x, bus.y, bus.falling);
    check("areset_x", 8'(bus.x), 8'd43);
    check("areset_y", 8'(bus.y), 8'd0);
    check("areset_falling", 8'(bus.falling), 8'd0);
    check("areset_landed", 8'(bus.landed), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.btn_d = 1'b1;
    tick();
    check("post_reset_y1", 8'(bus.y), 8'd1);
    check("post_reset_falling", 8'(bus.falling), 8'd0);
    tick();
    check("post_reset_y2", 8'(bus.y), 8'd2);
    check("post_reset_x", 8'(bus.x), 8'd43);
    bus.btn_d = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
